crc_rx_stream: RTL

CRC_RX_STREAM -- requirements
Module: crc_rx_stream

---
 rtl/crc_rx_stream.sv | 115 +++++++++++
 1 files changed

// File: rtl/crc_rx_stream.sv
// Streaming CRC checker: accepts a codeword, folds STEP bits per clock into a
// long-division remainder, then presents the payload with a pass/fail verdict.
module crc_rx_stream #(
   parameter int unsigned BW     = 40,
   parameter int unsigned CRC_BW = 8,
   parameter logic [CRC_BW-1:0] POLY = 'h07,
   parameter int unsigned STEP   = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [BW+CRC_BW-1:0]   in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BW-1:0]          out,
   output logic                   crc_ok,
   output logic [CNT_W-1:0]       err_cnt,
   input  logic                   clr_cnt
);

   localparam int unsigned W      = BW + CRC_BW;
   localparam int unsigned NCYC   = W / STEP;
   localparam int unsigned CNT_BW = $clog2(NCYC + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e              state_q, state_d;
   logic [W-1:0]        sh_q, sh_d;
   logic [CRC_BW-1:0]   syn_q, syn_d, syn_fold;
   logic [CNT_BW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]       out_q, out_d;
   logic                ok_q, ok_d;

   // Long division: shift codeword bits into the remainder, reduce on overflow.
   always_comb begin
      logic msb;
      syn_fold = syn_q;
      for (int i = 0; i < int'(STEP); i++) begin
         msb      = syn_fold[CRC_BW-1];
         syn_fold = (syn_fold << 1) | CRC_BW'(sh_q[W-1-i]);
         if (msb) syn_fold = syn_fold ^ POLY;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      syn_d   = syn_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      ok_d    = ok_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               sh_d    = in;
               syn_d   = '0;
               cnt_d   = '0;
               out_d   = in[W-1 -: BW];
               state_d = StCalc;
            end
         end
         StCalc: begin
            // One extra cycle after the last fold registers the verdict.
            if (cnt_q == CNT_BW'(NCYC)) begin
               ok_d    = (syn_q == '0);
               state_d = StDone;
            end else begin
               syn_d = syn_fold;
               sh_d  = sh_q << STEP;
               cnt_d = cnt_q + CNT_BW'(1);
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         sh_q    <= '0;
         syn_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         syn_q   <= syn_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ok_q    <= ok_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (out_valid && out_ready && !ok_q && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign out       = out_q;
   assign crc_ok    = ok_q;

endmodule
